// File: rtl/command_ack_packer.sv
// command_ack_packer: buffers 64-bit read-command acks and emits them as
// header-prefixed report frames, triggered by batch size or idle timeout.
module command_ack_packer #(
  parameter int ACK_DEPTH = 16,
  parameter int MAX_BATCH = 8,
  parameter int TIMEOUT   = 1000
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [63:0]                  iv_rd_command_ack,
  input  logic                         i_rd_command_ack_wr,
  input  logic                         i_frame_ready,
  output logic [63:0]                  ov_frame_data,
  output logic                         o_frame_valid,
  output logic                         o_frame_sop,
  output logic                         o_frame_eop,
  output logic                         o_overflow,
  output logic [$clog2(ACK_DEPTH):0]   ov_fifo_count
);
  localparam int AW = $clog2(ACK_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_C = ACK_DEPTH[CW-1:0];
  localparam logic [CW-1:0] MB_C   = MAX_BATCH[CW-1:0];
  localparam logic [TW-1:0] TO_C   = TIMEOUT[TW-1:0];
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  logic [63:0]   mem [ACK_DEPTH];
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   seq_q, seq_d;
  logic [7:0]    n_q, n_d, rem_q, rem_d;
  logic          ovf_q, full, pop, push, trig, last;
  always_comb begin
    full    = count_q == FULL_C;
    pop     = state_q == DATA && i_frame_ready;
    push    = i_rd_command_ack_wr && (!full || pop);
    last    = rem_q == 8'd1;
    trig    = state_q == IDLE && (count_q >= MB_C || timer_q == TO_C);
    count_d = count_q + CW'(push) - CW'(pop);
    n_d     = count_q >= MB_C ? MAX_BATCH[7:0] : 8'(count_q);
    state_d = state_q == IDLE ? (trig ? HDR : IDLE) :
              state_q == HDR  ? (i_frame_ready ? DATA : HDR) :
              (pop && last) ? IDLE : DATA;
    // the flush timer only runs while idle with data waiting
    timer_d = (state_q != IDLE || trig || count_q == '0) ? '0 :
              timer_q == TO_C ? timer_q : timer_q + TW'(1);
    rem_d   = trig ? n_d : pop ? rem_q - 8'd1 : rem_q;
    seq_d   = (pop && last) ? seq_q + 16'd1 : seq_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      seq_q    <= '0;
      n_q      <= '0;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_q  <= count_d;
      timer_q  <= timer_d;
      seq_q    <= seq_d;
      n_q      <= trig ? n_d : n_q;
      rem_q    <= rem_d;
      ovf_q    <= i_rd_command_ack_wr && full && !pop;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst && push) mem[wr_ptr_q] <= iv_rd_command_ack;
  end
  always_comb begin
    ov_frame_data = state_q == HDR  ? {8'hA5, n_q, seq_q, 32'h0} :
                    state_q == DATA ? mem[rd_ptr_q] : 64'h0;
    o_frame_valid = state_q != IDLE;
    o_frame_sop   = state_q == HDR;
    o_frame_eop   = state_q == DATA && last;
    o_overflow    = ovf_q;
    ov_fifo_count = count_q;
  end
endmodule

// File: doc/command_ack_packer.md
COMMAND_ACK_PACKER -- requirements
Module: command_ack_packer

Interface
REQ-001 Parameter ACK_DEPTH, default 16, SHALL set the ack FIFO depth in 64-bit words (power of two).
REQ-002 Parameter MAX_BATCH, default 8, SHALL set the maximum number of acks per frame (1..ACK_DEPTH, at most 255).
REQ-003 Parameter TIMEOUT, default 1000, SHALL set the flush timeout in clock cycles (at least 1).
REQ-004 i_clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 iv_rd_command_ack  in  64  read-command ack word from the ack type parser.
REQ-007 i_rd_command_ack_wr  in  1  one-cycle write strobe qualifying iv_rd_command_ack.
REQ-008 i_frame_ready  in  1  downstream ready for the report frame.
REQ-009 ov_frame_data  out  64  report frame word.
REQ-010 o_frame_valid  out  1  ov_frame_data valid.
REQ-011 o_frame_sop  out  1  first word of the frame (header).
REQ-012 o_frame_eop  out  1  last word of the frame.
REQ-013 o_overflow  out  1  one-cycle pulse when an ack is dropped.
REQ-014 ov_fifo_count  out  log2(ACK_DEPTH)+1  current FIFO occupancy.

Function
REQ-015 On a strobe with the FIFO not full, or full with a pop in the same cycle, the word SHALL be written and visible at the FIFO head from the next cycle.
REQ-016 On a strobe with the FIFO full and no pop in that cycle, the word SHALL be dropped and o_overflow SHALL be 1 in the next cycle only.
REQ-017 ov_fifo_count SHALL equal the count of the previous cycle, plus accepted writes, minus pops; it SHALL never exceed ACK_DEPTH or go below 0.
REQ-018 The FSM SHALL have the states IDLE, HDR and DATA.
REQ-019 In IDLE, a timer SHALL hold 0 while the FIFO is empty, SHALL increment each cycle while the FIFO is non-empty, and SHALL saturate at TIMEOUT.
REQ-020 IDLE to HDR SHALL occur when the count is at least MAX_BATCH or the timer equals TIMEOUT.
  - Batch size n SHALL be latched as min(count, MAX_BATCH).
  - The timer SHALL clear.
REQ-021 In HDR the outputs SHALL be: o_frame_valid=1, o_frame_sop=1, o_frame_eop=0.
  - ov_frame_data[63:56]=8'hA5.
  - [55:48]=n.
  - [47:32]=the 16-bit frame sequence number.
  - [31:0]=0.
REQ-022 HDR SHALL go to DATA on the first cycle in which i_frame_ready=1.
REQ-023 In DATA, ov_frame_data SHALL be the FIFO head and o_frame_valid=1.
  - Each cycle with i_frame_ready=1 SHALL pop one word and decrement the remaining count.
  - o_frame_eop=1 SHALL be asserted on the word with remaining count = 1.
REQ-024 On eop accepted, the FSM SHALL return to IDLE and the sequence number SHALL increment, wrapping 16'hFFFF to 0.
REQ-025 While o_frame_valid=1 and i_frame_ready=0, ov_frame_data, o_frame_sop and o_frame_eop SHALL hold stable.
REQ-026 In IDLE, o_frame_valid, o_frame_sop and o_frame_eop SHALL be 0 and ov_frame_data SHALL be 0.
REQ-027 Writes SHALL continue to be accepted during HDR and DATA.
  - Acks arriving mid-frame SHALL NOT join the current frame.
  - They SHALL count toward the next frame.
REQ-028 The timer SHALL NOT run outside IDLE. After return to IDLE with the FIFO non-empty, it SHALL restart from 0.
REQ-029 Latency: with i_frame_ready=1, the header SHALL appear 1 cycle after the trigger condition, and the frame SHALL take n+1 consecutive cycles.

Reset
REQ-030 While i_rst=1 at a clock edge, the following SHALL clear:
  - FIFO pointers, count, timer and sequence number, all to 0.
  - FSM to IDLE.
  - All outputs to 0.
REQ-031 A reset during HDR or DATA SHALL abandon the frame: no eop is produced and buffered acks are discarded.
REQ-032 A strobe in a reset cycle SHALL be ignored.

Verification
REQ-033 Batch trigger: 8 strobes on consecutive cycles with data 1..8, ready=1. Required response:
  - Header A5_08_0000_00000000 with sop.
  - Then words 1..8, eop on 8.
  - o_overflow stays 0.
REQ-034 Timeout: 3 strobes (data 0xA,0xB,0xC), then idle, ready=1. Required response:
  - Header with n=3 appears 1 cycle after the timer reaches 1000.
  - Then 0xA,0xB,0xC, eop on 0xC.
  - The next frame has sequence 1.
REQ-035 Backpressure: ready=0 for 5 cycles during HDR, then ready toggles 1/0 during DATA. Required response:
  - Header and each word held stable until accepted.
  - No word lost or duplicated.
REQ-036 Overflow: ready=0, 17 strobes. Required response:
  - Count saturates at 16.
  - o_overflow pulses once, for the 17th strobe.
  - After ready=1, frames of 8 and 8 carry the first 16 words in order.
REQ-037 Simultaneous write and pop when full: a strobe in the same cycle as a DATA pop with count=16. Required response:
  - Write accepted, count stays 16, no overflow.
REQ-038 Reset mid-DATA: i_rst=1 for 1 cycle after 3 of 8 words are accepted. Required response:
  - Outputs 0, count 0, no eop.
  - The next frame has sequence 0.
